udp_regs_readback: RTL and testbench

- Read-side companion to the UDP register-write block.
- Snoops the same validated UDP payload byte stream and decodes read-request packets (cmd 0x01, subcmd 0x01).
- Snapshots the register bank and serializes a reply packet onto the shared UDP TX path.
- Acquires the TX path through a req/grant handshake with the TX arbiter, with a grant timeout and drop accounting.

---
 rtl/udp_regs_readback.sv | 165 ++++++++++++++++
 tb/tb_udp_regs_readback.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_regs_readback.sv
// Read-request decoder for the UDP register bank: snapshots the registers on a
// valid 4-byte read request and streams a reply packet onto the shared TX path.
module udp_regs_readback #(
  parameter int NUM_REGS      = 4,
  parameter int GRANT_TIMEOUT = 1024
) (
  input  logic                   c,
  input  logic                   rst_n,
  input  logic [7:0]             rxd,
  input  logic                   rxdv,
  input  logic                   rxlast,
  input  logic [NUM_REGS*32-1:0] regs,
  output logic                   tx_req,
  input  logic                   tx_grant,
  output logic [7:0]             txd,
  output logic                   txdv,
  output logic                   txlast,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, SEND} state_t;

  state_t                state, state_n;
  logic [11:0]           bcnt;
  logic [7:0]            hdr_cmd, hdr_sub, hdr_start;
  logic [7:0]            start_q, count_q;
  logic [NUM_REGS*32-1:0] snap;
  logic [15:0]           wcnt, wcnt_n;
  logic [9:0]            idx, idx_n;
  logic [9:0]            last_idx;
  logic [7:0]            txd_n, drop_n;
  logic                  txdv_n, txlast_n, req_n, busy_n;
  logic [1:0]            drops;
  logic                  valid_req, accept;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Reply byte i: 4 header bytes, then little-endian words of start+k (no wrap).
  function automatic logic [7:0] reply_byte(input logic [9:0] i, input logic [7:0] st,
                                            input logic [7:0] cnt,
                                            input logic [NUM_REGS*32-1:0] sn);
    logic [9:0] off;
    logic [8:0] ri;
    logic [7:0] b;
    off = i - 10'd4;
    ri  = {1'b0, st} + {1'b0, off[9:2]};
    b   = 8'h00;
    if (i == 10'd0)                b = 8'h01;
    else if (i == 10'd1)           b = 8'h81;
    else if (i == 10'd2)           b = st;
    else if (i == 10'd3)           b = cnt;
    else if (int'(ri) < NUM_REGS)  b = sn[int'(ri)*32 + int'(off[1:0])*8 +: 8];
    return b;
  endfunction

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n)     bcnt <= 12'd0;
    else if (!rxdv) bcnt <= 12'd0;
    else            bcnt <= bcnt + 12'd1;
  end

  always_ff @(posedge c) begin
    if (rxdv) begin
      if (bcnt == 12'd0) hdr_cmd   <= rxd;
      if (bcnt == 12'd1) hdr_sub   <= rxd;
      if (bcnt == 12'd2) hdr_start <= rxd;
    end
  end

  // The count byte is judged directly off the wire on the closing byte.
  assign valid_req = rxdv && rxlast && (bcnt == 12'd3) && (hdr_cmd == 8'h01) &&
                     (hdr_sub == 8'h01) && (rxd != 8'h00) && (rxd <= 8'd64);
  assign accept    = valid_req && (state == IDLE);
  assign last_idx  = {count_q, 2'b00} + 10'd3;

  always_ff @(posedge c) begin
    if (accept) begin
      snap    <= regs;
      start_q <= hdr_start;
      count_q <= rxd;
    end
  end

  always_comb begin
    state_n  = state;
    wcnt_n   = wcnt;
    idx_n    = idx;
    txd_n    = txd;
    txdv_n   = txdv;
    txlast_n = txlast;
    req_n    = tx_req;
    drops    = 2'd0;
    case (state)
      IDLE: begin
        if (valid_req) begin
          state_n = WAIT_GRANT;
          wcnt_n  = 16'd0;
          req_n   = 1'b1;
        end
      end
      WAIT_GRANT: begin
        if (tx_grant) begin
          state_n  = SEND;
          txd_n    = 8'h01;
          txdv_n   = 1'b1;
          txlast_n = 1'b0;
          idx_n    = 10'd1;
        end else if (wcnt == 16'(GRANT_TIMEOUT - 1)) begin
          state_n = IDLE;
          req_n   = 1'b0;
          drops   = drops + 2'd1;
        end else begin
          wcnt_n = wcnt + 16'd1;
        end
      end
      SEND: begin
        if (txlast) begin
          state_n  = IDLE;
          req_n    = 1'b0;
          txdv_n   = 1'b0;
          txlast_n = 1'b0;
          txd_n    = 8'h00;
        end else begin
          txd_n    = reply_byte(idx, start_q, count_q, snap);
          txlast_n = (idx == last_idx);
          idx_n    = idx + 10'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (valid_req && (state != IDLE)) drops = drops + 2'd1;
    busy_n = (state_n != IDLE);
    drop_n = sat_add(drop_cnt, drops);
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wcnt     <= 16'd0;
      idx      <= 10'd0;
      tx_req   <= 1'b0;
      txd      <= 8'h00;
      txdv     <= 1'b0;
      txlast   <= 1'b0;
      busy     <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      state    <= state_n;
      wcnt     <= wcnt_n;
      idx      <= idx_n;
      tx_req   <= req_n;
      txd      <= txd_n;
      txdv     <= txdv_n;
      txlast   <= txlast_n;
      busy     <= busy_n;
      drop_cnt <= drop_n;
    end
  end

endmodule

// File: tb/tb_udp_regs_readback.sv
// Bench for udp_regs_readback: directed and randomized read requests checked
// against a packet-level reference model of replies and drop accounting.
module tb_udp_regs_readback;

  logic        c;
  logic        rst_n;
  logic [7:0]  rxd;
  logic        rxdv;
  logic        rxlast;
  logic [127:0] regs_bus;
  logic        tx_req;
  logic        tx_grant;
  logic [7:0]  txd;
  logic        txdv;
  logic        txlast;
  logic        busy;
  logic [7:0]  drop_cnt;

  logic [31:0] rv[4];
  logic [31:0] acc_regs[4];
  logic [7:0]  acc_start, acc_count;
  logic [7:0]  pkt[$];
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  int          total, bad, drop_exp, first_at, n_last;
  logic        last_busy;

  assign regs_bus = {rv[3], rv[2], rv[1], rv[0]};

  udp_regs_readback #(.NUM_REGS(4), .GRANT_TIMEOUT(8)) dut (
    .c(c), .rst_n(rst_n), .rxd(rxd), .rxdv(rxdv), .rxlast(rxlast), .regs(regs_bus),
    .tx_req(tx_req), .tx_grant(tx_grant), .txd(txd), .txdv(txdv), .txlast(txlast),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  always @(negedge c) if (txdv && txlast) n_last++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  function automatic int sat255(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  function automatic bit is_valid();
    return (pkt.size() == 4) && (pkt[0] == 8'h01) && (pkt[1] == 8'h01) &&
           (pkt[3] >= 8'd1) && (pkt[3] <= 8'd64);
  endfunction

  task automatic set4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s,
                      input logic [7:0] n);
    pkt.delete();
    pkt.push_back(a); pkt.push_back(b); pkt.push_back(s); pkt.push_back(n);
  endtask

  task automatic drive_pkt();
    bit v;
    v = is_valid();
    for (int i = 0; i < pkt.size(); i++) begin
      @(posedge c); #1;
      rxd = pkt[i]; rxdv = 1'b1; rxlast = (i == pkt.size() - 1);
    end
    @(negedge c);
    last_busy = busy;
    if (v && !last_busy) begin
      acc_start = pkt[2];
      acc_count = pkt[3];
      acc_regs  = rv;
    end
    @(posedge c); #1;
    rxdv = 1'b0; rxlast = 1'b0; rxd = 8'h00;
    if (v && last_busy) drop_exp++;
    if (!last_busy) chk("req_after_pkt", 32'(tx_req), 32'(v));
  endtask

  task automatic collect(input int budget);
    bit started, seen_last, gap;
    started = 0; seen_last = 0; gap = 0; first_at = -1;
    got.delete();
    for (int i = 0; i < budget && !seen_last; i++) begin
      @(negedge c);
      if (txdv) begin
        if (!started) first_at = i;
        started = 1;
        got.push_back(txd);
        if (txlast) seen_last = 1;
      end else if (started) gap = 1;
    end
    chk("reply_complete", 32'(seen_last), 32'd1);
    chk("reply_gapless", 32'(gap), 32'd0);
  endtask

  task automatic compare_reply();
    logic [31:0] w;
    int ri, n;
    exp_q.delete();
    exp_q.push_back(8'h01); exp_q.push_back(8'h81);
    exp_q.push_back(acc_start); exp_q.push_back(acc_count);
    for (int k = 0; k < int'(acc_count); k++) begin
      ri = int'(acc_start) + k;
      w  = (ri < 4) ? acc_regs[ri] : 32'h0;
      for (int j = 0; j < 4; j++) exp_q.push_back(w[8*j +: 8]);
    end
    chk("reply_len", 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("reply_byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
    chk("drop_cnt", 32'(drop_cnt), 32'(sat255(drop_exp)));
    @(negedge c);
    chk("busy_after_reply", 32'(busy), 32'd0);
  endtask

  initial begin
    int n, d, len, nl0;
    logic [7:0] s, cn, b;
    total = 0; bad = 0; drop_exp = 0; n_last = 0;
    rv[0] = 32'h11111111; rv[1] = 32'h22222222; rv[2] = 32'h33333333; rv[3] = 32'h44444444;
    rst_n = 1'b0; rxd = 8'h00; rxdv = 1'b0; rxlast = 1'b0; tx_grant = 1'b1;
    repeat (3) @(posedge c);
    #1;
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_txd", 32'(txd), 32'd0);
    chk("rst_txdv", 32'(txdv), 32'd0);
    chk("rst_txlast", 32'(txlast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge c) rst_n = 1'b1;

    set4(8'h01, 8'h01, 8'h01, 8'h02); drive_pkt();
    collect(300);
    chk("first_byte_latency", 32'(first_at), 32'd1);
    compare_reply();
    set4(8'h01, 8'h01, 8'h03, 8'h03); drive_pkt(); collect(300); compare_reply();
    set4(8'h01, 8'h01, 8'hFF, 8'h02); drive_pkt(); collect(300); compare_reply();

    set4(8'h01, 8'h00, 8'h00, 8'h00); drive_pkt();
    set4(8'h01, 8'h01, 8'h00, 8'h01); pkt.push_back(8'h05); drive_pkt();
    set4(8'h01, 8'h01, 8'h00, 8'h00); drive_pkt();
    set4(8'h01, 8'h01, 8'h00, 8'h41); drive_pkt();
    repeat (3) @(negedge c);
    chk("reject_no_req", 32'(tx_req), 32'd0);
    chk("reject_drop", 32'(drop_cnt), 32'd0);

    tx_grant = 1'b0;
    set4(8'h01, 8'h01, 8'h00, 8'h01); drive_pkt();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge c);
      if (tx_req) n++;
    end
    drop_exp++;
    chk("timeout_req_cycles", 32'(n), 32'd8);
    chk("timeout_drop", 32'(drop_cnt), 32'(sat255(drop_exp)));
    chk("timeout_busy", 32'(busy), 32'd0);
    set4(8'h01, 8'h01, 8'h00, 8'h04); drive_pkt();
    repeat (3) @(posedge c);
    #1 tx_grant = 1'b1;
    collect(300); compare_reply();

    tx_grant = 1'b0;
    set4(8'h01, 8'h01, 8'h00, 8'h02); drive_pkt();
    rv[0] = 32'hDEADBEEF;
    repeat (3) @(posedge c);
    #1 tx_grant = 1'b1;
    fork
      collect(300);
      begin
        repeat (2) @(posedge c);
        set4(8'h01, 8'h01, 8'h02, 8'h01);
        drive_pkt();
      end
    join
    chk("busy_drop_count", 32'(drop_exp), 32'd2);
    compare_reply();

    for (int it = 0; it < 25; it++) begin
      for (int r = 0; r < 4; r++) rv[r] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        s  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(250, 255));
        cn = ($urandom_range(0, 3) == 0) ? 8'd64 : 8'($urandom_range(1, 12));
        set4(8'h01, 8'h01, s, cn);
      end else begin
        len = $urandom_range(1, 6);
        pkt.delete();
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom_range(0, 255));
          if (i < 2 && $urandom_range(0, 2) != 0) b = 8'h01;
          if (i == 3 && $urandom_range(0, 1) == 1) b = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(65, 255));
          pkt.push_back(b);
        end
      end
      d = $urandom_range(0, 4);
      tx_grant = (d == 0);
      if (is_valid()) begin
        drive_pkt();
        repeat (d) @(posedge c);
        #1 tx_grant = 1'b1;
        collect(300);
        compare_reply();
      end else begin
        drive_pkt();
        repeat (2) @(negedge c);
        chk("rand_reject_no_req", 32'(tx_req), 32'd0);
        chk("rand_reject_drop", 32'(drop_cnt), 32'(sat255(drop_exp)));
      end
    end
    tx_grant = 1'b1;

    nl0 = n_last;
    set4(8'h01, 8'h01, 8'h00, 8'h40); drive_pkt();
    repeat (20) @(posedge c);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_req", 32'(tx_req), 32'd0);
    chk("arst_txdv", 32'(txdv), 32'd0);
    chk("arst_txlast", 32'(txlast), 32'd0);
    chk("arst_txd", 32'(txd), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    repeat (3) @(negedge c);
    chk("arst_no_txlast", 32'(n_last), 32'(nl0));
    drop_exp = 0;
    rst_n = 1'b1;

    set4(8'h01, 8'h01, 8'h01, 8'h03); drive_pkt(); collect(300); compare_reply();

    for (int i = 0; i < 2000 && drop_exp < 300; i++) begin
      set4(8'h01, 8'h01, 8'h00, 8'h40);
      drive_pkt();
      if (drop_exp == 100 && last_busy) chk("drop_mid", 32'(drop_cnt), 32'd100);
    end
    chk("drop_rejects_seen", 32'(drop_exp), 32'd300);
    chk("drop_saturated", 32'(drop_cnt), 32'hFF);
    for (int i = 0; i < 400 && busy; i++) @(negedge c);
    chk("final_idle", 32'(busy), 32'd0);
    chk("drop_still_sat", 32'(drop_cnt), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
